// File: rtl/dmem_bus_responder.sv
// dmem_bus_responder: data-memory responder for the core's load/store port.
// One request is outstanding at a time. The request handshake is followed by
// WAIT_CYCLES wait states, then the access, then a held response handshake.
// Optional build macro DMEM_BUS_ERR_CHECK_EN enables range and alignment
// error reporting; without it rsp_err is tied low and addresses wrap.
module dmem_bus_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  waitCnt;
  logic        readyQ;
  logic        rspValidQ;
  logic [31:0] rspRdataQ;
  logic        rspErrQ;

  // Captured request, used once the wait states have elapsed
  logic        regWe;
  logic [31:0] regAddr;
  logic [31:0] regWdata;
  logic [3:0]  regBe;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          doAccess;
  logic          accessWe;
  logic [31:0]   accessAddr;
  logic [31:0]   accessWdata;
  logic [3:0]    accessBe;
  logic [31:0]   offset;
  logic [AW-1:0] wordIdx;
  logic          accessErr;
  logic          unusedOffsetBits;

  assign accept = req_valid && readyQ;

  // With zero wait states the access happens on the accept edge itself, so
  // the live request is used; otherwise the captured copy is.
  assign doAccess = (accept && (WAIT_INIT == 4'd0)) ||
                    ((state == WAIT) && (waitCnt == 4'd1));

  assign accessWe    = (state == IDLE) ? req_we    : regWe;
  assign accessAddr  = (state == IDLE) ? req_addr  : regAddr;
  assign accessWdata = (state == IDLE) ? req_wdata : regWdata;
  assign accessBe    = (state == IDLE) ? req_be    : regBe;

  // Byte offset from the window base; only the word-index bits address the
  // array, so out-of-window offsets wrap when checking is disabled.
  assign offset  = accessAddr - BASE_ADDR;
  assign wordIdx = offset[AW+1:2];
  assign unusedOffsetBits = ^{offset[31:AW+2], offset[1:0]};

`ifdef DMEM_BUS_ERR_CHECK_EN
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;
  logic outOfRange;
  logic misaligned;
  // Subtraction wraps for addresses below the base, so one compare covers both ends
  assign outOfRange = ({1'b0, offset} >= SPAN);
  assign misaligned = accessWe &&
                      (((accessBe == 4'b1111) && (accessAddr[1:0] != 2'b00)) ||
                       (((accessBe == 4'b0011) || (accessBe == 4'b1100)) &&
                        accessAddr[0]));
  assign accessErr = outOfRange || misaligned;
`else
  assign accessErr = 1'b0;
`endif

  assign req_ready = readyQ;
  assign rsp_valid = rspValidQ;
  assign rsp_rdata = rspRdataQ;
  assign rsp_err   = rspErrQ;

  // Request capture: data registers, loaded only on an accepted handshake
  always_ff @(posedge clock) begin
    if (accept) begin
      regWe    <= req_we;
      regAddr  <= req_addr;
      regWdata <= req_wdata;
      regBe    <= req_be;
    end
  end

  // Storage array: byte-lane writes at the access edge, suppressed on error
  always_ff @(posedge clock) begin
    if (doAccess && accessWe && !accessErr) begin
      for (int i = 0; i < 4; i++) begin
        if (accessBe[i]) mem[wordIdx][8*i +: 8] <= accessWdata[8*i +: 8];
      end
    end
  end

  // Control FSM and response registers; reset aborts any pending access
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      waitCnt   <= 4'd0;
      readyQ    <= 1'b0;
      rspValidQ <= 1'b0;
      rspRdataQ <= 32'h0;
      rspErrQ   <= 1'b0;
    end else begin
      // Ready follows IDLE by one cycle, which also forbids same-cycle turnaround
      readyQ <= (state == IDLE) && !accept;

      case (state)
        IDLE: begin
          if (accept) begin
            waitCnt <= WAIT_INIT;
            state   <= doAccess ? RESP : WAIT;
          end
        end
        WAIT: begin
          waitCnt <= 4'(waitCnt - 4'd1);
          if (doAccess) state <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (doAccess) begin
        rspValidQ <= 1'b1;
        rspRdataQ <= (accessWe || accessErr) ? 32'h0 : mem[wordIdx];
        rspErrQ   <= accessErr;
      end else if ((state == RESP) && rsp_ready) begin
        rspValidQ <= 1'b0;
        rspRdataQ <= 32'h0;
        rspErrQ   <= 1'b0;
      end
    end
  end

endmodule
